sr_cpu_fetch_with_latency: RTL and testbench
============================================

# sr_cpu_fetch_with_latency

Single-cycle-datapath RISC-V (schoolRISCV subset) CPU `sr_cpu` paired with a synchronous-read instruction memory `instruction_rom` that has one clock of read latency. The CPU alternates a fetch phase and an execute phase, so each instruction takes exactly two clocks. A debug port reads any architectural register combinationally; system integration observes register a0 (x10) for program results.

## Interface
Parameters (instruction_rom):
- `SIZE` — default 1024 — number of 32-bit words in the ROM; the address width is `$clog2(SIZE)`.

Ports, sr_cpu:
- `clk` — in, 1 — single clock, rising edge.
- `rst` — in, 1 — reset, synchronous and active-high.
- `imAddr` — out, 32 — instruction word address, equal to `pc[31:2]` zero-extended.
- `imData` — in, 32 — instruction word from the ROM.
- `regAddr` — in, 5 — debug register index.
- `regData` — out, 32 — combinational read of register[`regAddr`]; x0 reads 0.

Ports, instruction_rom:
- `clk` — in, 1 — same clock.
- `a` — in, `$clog2(SIZE)` — word address; the integrator connects the truncated `imAddr`.
- `rd` — out, 32 — registered read data.

## Operation
- ROM: array of `SIZE` 32-bit words, initialised with `$readmemh("program.hex")`. On each rising edge, `rd <= rom[a]`. There is no reset and no write port.
- CPU state:
  - `pc`: 32 bits, reset value 0.
  - `phase`: 1 bit, reset value 0 (0 = fetch/wait, 1 = execute).
  - Register file: 32×32; x0 is hardwired to 0.
- `phase` toggles every clock when not in reset.
- Fetch phase (`phase` = 0): `imAddr` presents the current `pc`. No architectural state changes.
- Execute phase (`phase` = 1): `imData` holds the instruction at `pc`. It is decoded and executed. At the clock edge:
  - the destination register is written, unless rd is x0;
  - `pc` is updated to the next PC.
- Supported instructions:
  - R-type, opcode 0110011: add (funct3 000, funct7 0000000), sub (000/0100000), or (110), srl (101), sltu (011).
  - I-type, opcode 0010011: addi (funct3 000), with a sign-extended 12-bit immediate.
  - U-type, opcode 0110111: lui, which loads `{imm[31:12], 12'b0}`.
  - B-type, opcode 1100011: beq (funct3 000) and bne (001), with a sign-extended 13-bit offset whose bit 0 is 0.
- Next PC:
  - `pc + imm_B` for a taken branch;
  - `pc + 4` otherwise.
- Any unsupported encoding executes as a NOP: no register write and `pc + 4`.
- ALU arithmetic is 32-bit wrap-around.
  - srl shifts by `rs2[4:0]`.
  - sltu is an unsigned compare that produces 0 or 1.
  - The branch compare is 32-bit equality.
- Register reads are combinational from `rs1`/`rs2`. A write is visible on `regData` in the clock after the execute edge.

## Timing
- During reset:
  - `pc` = 0, so `imAddr` = 0;
  - `phase` = 0;
  - register-file contents are cleared to 0, so `regData` = 0.
- Because the ROM samples `imAddr` = 0 during reset, `imData` is already valid in the first cycle after reset.
- First clock edge after reset release: fetch phase, no state change.
- Second clock edge: instruction 0 retires.
- In general, instruction k retires on edge 2k+2 after release; `imAddr` changes only on execute edges.
- `imData` is consumed only when `phase` = 1. At those edges it holds `rom[imAddr]` registered in the prior cycle, and it must contain no X for valid program addresses.
- Branch redirect takes effect immediately: the next fetch phase presents the target address, with no delay slot and no stale fetch.
- Reset asserted mid-program: at the next edge, `pc`, `phase` and the registers return to their reset values.

## Test plan
- Reset, then observe with `regAddr` = 10:
  - during reset, `imAddr` = 0 and `regData` = 0;
  - after release, `imAddr` stays 0 for 2 edges and then becomes 1.
- Program `addi a0,x0,5; addi a0,a0,-7`: `regData` shows 5, then 0xFFFFFFFE two clocks later.
- Program `addi x0,x0,9; lui a0,0x12345; beq x0,x0,-4`:
  - x0 stays 0;
  - a0 = 0x12345000;
  - the branch loops back, so `imAddr` alternates 1↔2, each held for 2 clocks.
- ALU checks: a0 = sub(3,5) → 0xFFFFFFFE; sltu(3,5) → 1; srl(0x80000000,31) → 1; or(0xF0,0x0F) → 0xFF.
- Iterative Fibonacci program: a0 reaches 0x00213D05 within 1000 clocks after reset.
- Iterative add-based factorial program: a0 reaches 0x1C8CFC00 (12!) within 1000 clocks.
- Assert reset mid-run of the Fibonacci program: `imAddr` returns to 0, a0 returns to 0, and on release the sequence repeats identically.

Source files
------------

// File: rtl/sr_cpu_fetch_with_latency.sv
// sr_cpu_fetch_with_latency: schoolRISCV-subset CPU paired with a ROM that has
// one clock of read latency. Each instruction takes two clocks: a fetch phase
// that presents pc to the ROM, then an execute phase that retires it.
//
// The ROM image comes in through the PROGRAM parameter. Word i sits in bits
// [32*i +: 32], so the integrator can build it from program.hex at elaboration
// time.
//
// Ports (top):
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous active-high reset
//   regAddr in   5   debug register index
//   regData out  32  combinational read of register[regAddr]; x0 reads 0
//   imAddr  out  32  instruction word address, pc[31:2] zero-extended

// Synchronous-read instruction ROM: no reset and no write port.
//   clk in 1; a in $clog2(SIZE) word address; rd out 32 registered data
module instruction_rom #(
   parameter int unsigned        SIZE = 1024,
   parameter logic [SIZE*32-1:0] INIT = '0
) (
   input  logic                    clk,
   input  logic [$clog2(SIZE)-1:0] a,
   output logic [31:0]             rd
);

   logic [31:0] rom [SIZE];

   // Unpack the constant image into words.
   for (genvar i = 0; i < SIZE; i++) begin : g_word
      assign rom[i] = INIT[32*i +: 32];
   end

   // One-clock read latency.
   always_ff @(posedge clk) begin
      rd <= rom[a];
   end

endmodule

// Two-phase CPU core.
//   clk, rst    clock and synchronous active-high reset
//   imAddr  out 32  word address of the instruction being fetched
//   imData  in  32  instruction word, valid during the execute phase
//   regAddr in  5   debug register index
//   regData out 32  combinational debug read
module sr_cpu (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imAddr,
   input  logic [31:0] imData,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData
);

   localparam logic [6:0] OPC_REG    = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic {
      PH_FETCH = 1'b0,
      PH_EXEC  = 1'b1
   } phase_t;

   phase_t      phase;
   phase_t      phaseNext;
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic [31:0] rf [32];

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] immI;
   logic [31:0] immU;
   logic [31:0] immB;
   logic [31:0] rs1Val;
   logic [31:0] rs2Val;
   logic [31:0] wbData;
   logic        wbEn;
   logic        branchTaken;
   logic        rfWe;

   // Instruction fields.
   assign opcode = imData[6:0];
   assign rd     = imData[11:7];
   assign funct3 = imData[14:12];
   assign rs1    = imData[19:15];
   assign rs2    = imData[24:20];
   assign funct7 = imData[31:25];

   // Immediates.
   assign immI = {{20{imData[31]}}, imData[31:20]};
   assign immU = {imData[31:12], 12'b0};
   assign immB = {{19{imData[31]}}, imData[31], imData[7], imData[30:25],
                  imData[11:8], 1'b0};

   // Operand and debug reads; x0 always reads zero.
   assign rs1Val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
   assign rs2Val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
   assign regData = (regAddr == 5'd0) ? 32'd0 : rf[regAddr];

   assign imAddr = {2'b00, pc[31:2]};

   // Decode and ALU. Any encoding not matched falls through as a NOP.
   always_comb begin
      wbData      = '0;
      wbEn        = 1'b0;
      branchTaken = 1'b0;
      case (opcode)
         OPC_REG: begin
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: begin wbData = rs1Val + rs2Val;                wbEn = 1'b1; end
               {7'b0100000, 3'b000}: begin wbData = rs1Val - rs2Val;                wbEn = 1'b1; end
               {7'b0000000, 3'b110}: begin wbData = rs1Val | rs2Val;                wbEn = 1'b1; end
               {7'b0000000, 3'b101}: begin wbData = rs1Val >> rs2Val[4:0];          wbEn = 1'b1; end
               {7'b0000000, 3'b011}: begin wbData = 32'(rs1Val < rs2Val);           wbEn = 1'b1; end
               default: ;
            endcase
         end
         OPC_IMM: begin
            if (funct3 == 3'b000) begin
               wbData = rs1Val + immI;
               wbEn   = 1'b1;
            end
         end
         OPC_LUI: begin
            wbData = immU;
            wbEn   = 1'b1;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000:  branchTaken = (rs1Val == rs2Val);
               3'b001:  branchTaken = (rs1Val != rs2Val);
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Phase sequencing. pc and the register file only move on execute edges.
   always_comb begin
      phaseNext = phase;
      pcNext    = pc;
      rfWe      = 1'b0;
      case (phase)
         PH_FETCH: begin
            phaseNext = PH_EXEC;
         end
         PH_EXEC: begin
            phaseNext = PH_FETCH;
            pcNext    = branchTaken ? (pc + immB) : (pc + 32'd4);
            rfWe      = wbEn && (rd != 5'd0);
         end
         default: begin
            phaseNext = PH_FETCH;
         end
      endcase
   end

   // Phase and pc registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= PH_FETCH;
         pc    <= '0;
      end else begin
         phase <= phaseNext;
         pc    <= pcNext;
      end
   end

   // Register file, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if (rfWe) begin
         rf[rd] <= wbData;
      end
   end

endmodule

// CPU plus ROM. The ROM is addressed by the low bits of imAddr.
module sr_cpu_fetch_with_latency #(
   parameter int unsigned        SIZE    = 1024,
   parameter logic [SIZE*32-1:0] PROGRAM = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic [31:0] imAddr
);

   localparam int unsigned AW = $clog2(SIZE);

   logic [31:0] imData;

   sr_cpu uCpu (
      .clk     (clk),
      .rst     (rst),
      .imAddr  (imAddr),
      .imData  (imData),
      .regAddr (regAddr),
      .regData (regData)
   );

   instruction_rom #(
      .SIZE (SIZE),
      .INIT (PROGRAM)
   ) uRom (
      .clk (clk),
      .a   (imAddr[AW-1:0]),
      .rd  (imData)
   );

endmodule

// File: tb/tb_sr_cpu_fetch_with_latency.sv
// Bench for sr_cpu_fetch_with_latency. Five instances run different programs
// in lockstep. An instruction-level reference model tracks pc and registers
// for each instance. Debug register indices and the position and length of
// the mid-run reset are randomized.
module tb_sr_cpu_fetch_with_latency;

   localparam int unsigned SIZE = 32;
   localparam int unsigned ROMW = SIZE * 32;
   localparam int          NDUT = 5;

   // Instruction encoders.
   function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   function automatic logic [31:0] encB(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   // Programs, highest address first (word 0 is the last item).
   localparam logic [ROMW-1:0] PROG0 = ROMW'({
      encB(13'd0, 5'd0, 5'd0, 3'b000),          // 2: beq x0,x0,0
      encI(12'hFF9, 5'd10, 3'b000, 5'd10),      // 1: addi a0,a0,-7
      encI(12'd5, 5'd0, 3'b000, 5'd10)          // 0: addi a0,x0,5
   });

   localparam logic [ROMW-1:0] PROG1 = ROMW'({
      encB(13'h1FFC, 5'd0, 5'd0, 3'b000),       // 2: beq x0,x0,-4
      encU(20'h12345, 5'd10),                   // 1: lui a0,0x12345
      encI(12'd9, 5'd0, 3'b000, 5'd0)           // 0: addi x0,x0,9
   });

   localparam logic [ROMW-1:0] PROG2 = ROMW'({
      encB(13'd0, 5'd0, 5'd0, 3'b000),          // 19: halt
      encI(12'd0, 5'd0, 3'b000, 5'd10),         // 18: addi a0,x0,0 (skipped)
      encB(13'd8, 5'd2, 5'd1, 3'b001),          // 17: bne x1,x2,+8 taken
      encB(13'd8, 5'd1, 5'd1, 3'b001),          // 16: bne x1,x1 not taken
      encB(13'd8, 5'd2, 5'd1, 3'b000),          // 15: beq x1,x2 not taken
      encI(12'd7, 5'd0, 3'b001, 5'd17),         // 14: I-type funct3 001 -> NOP
      32'hFFFF_FFFF,                            // 13: illegal -> NOP
      encR(7'h20, 5'd2, 5'd1, 3'b110, 5'd16),   // 12: bad funct7 -> NOP
      encR(7'h00, 5'd1, 5'd2, 3'b011, 5'd15),   // 11: sltu x15,x2,x1
      encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd14),   // 10: add x14,x1,x2
      encR(7'h00, 5'd6, 5'd5, 3'b110, 5'd13),   //  9: or x13,x5,x6
      encI(12'h00F, 5'd0, 3'b000, 5'd6),        //  8: addi x6,x0,0x0F
      encI(12'h0F0, 5'd0, 3'b000, 5'd5),        //  7: addi x5,x0,0xF0
      encR(7'h00, 5'd4, 5'd3, 3'b101, 5'd12),   //  6: srl x12,x3,x4
      encI(12'd31, 5'd0, 3'b000, 5'd4),         //  5: addi x4,x0,31
      encU(20'h80000, 5'd3),                    //  4: lui x3,0x80000
      encR(7'h00, 5'd2, 5'd1, 3'b011, 5'd11),   //  3: sltu x11,x1,x2
      encR(7'h20, 5'd2, 5'd1, 3'b000, 5'd10),   //  2: sub a0,x1,x2
      encI(12'd5, 5'd0, 3'b000, 5'd2),          //  1: addi x2,x0,5
      encI(12'd3, 5'd0, 3'b000, 5'd1)           //  0: addi x1,x0,3
   });

   localparam logic [ROMW-1:0] PROG3 = ROMW'({
      encB(13'd0, 5'd0, 5'd0, 3'b000),          // 8: halt
      encB(13'h1FF0, 5'd0, 5'd3, 3'b001),       // 7: bne x3,x0,-16
      encI(12'hFFF, 5'd3, 3'b000, 5'd3),        // 6: addi x3,x3,-1
      encI(12'd0, 5'd4, 3'b000, 5'd10),         // 5: b = t
      encI(12'd0, 5'd10, 3'b000, 5'd1),         // 4: a = b
      encR(7'h00, 5'd10, 5'd1, 3'b000, 5'd4),   // 3: t = a + b
      encI(12'd31, 5'd0, 3'b000, 5'd3),         // 2: count = 31
      encI(12'd1, 5'd0, 3'b000, 5'd10),         // 1: b = 1
      encI(12'd0, 5'd0, 3'b000, 5'd1)           // 0: a = 0
   });

   localparam logic [ROMW-1:0] PROG4 = ROMW'({
      encB(13'd0, 5'd0, 5'd0, 3'b000),          // 11: halt
      encB(13'h1FE4, 5'd5, 5'd1, 3'b001),       // 10: bne x1,x5,-28
      encI(12'd1, 5'd1, 3'b000, 5'd1),          //  9: i++
      encI(12'd0, 5'd2, 3'b000, 5'd10),         //  8: r = acc
      encB(13'h1FF8, 5'd0, 5'd3, 3'b001),       //  7: bne x3,x0,-8
      encI(12'hFFF, 5'd3, 3'b000, 5'd3),        //  6: cnt--
      encR(7'h00, 5'd10, 5'd2, 3'b000, 5'd2),   //  5: acc += r
      encI(12'd0, 5'd1, 3'b000, 5'd3),          //  4: cnt = i
      encI(12'd0, 5'd0, 3'b000, 5'd2),          //  3: acc = 0
      encI(12'd13, 5'd0, 3'b000, 5'd5),         //  2: limit = 13
      encI(12'd2, 5'd0, 3'b000, 5'd1),          //  1: i = 2
      encI(12'd1, 5'd0, 3'b000, 5'd10)          //  0: r = 1
   });

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  regAddr [NDUT];
   logic [31:0] regData [NDUT];
   logic [31:0] imAddr  [NDUT];

   always #5 clk = ~clk;

   sr_cpu_fetch_with_latency #(.SIZE(SIZE), .PROGRAM(PROG0)) dut0 (
      .clk(clk), .rst(rst), .regAddr(regAddr[0]), .regData(regData[0]), .imAddr(imAddr[0]));
   sr_cpu_fetch_with_latency #(.SIZE(SIZE), .PROGRAM(PROG1)) dut1 (
      .clk(clk), .rst(rst), .regAddr(regAddr[1]), .regData(regData[1]), .imAddr(imAddr[1]));
   sr_cpu_fetch_with_latency #(.SIZE(SIZE), .PROGRAM(PROG2)) dut2 (
      .clk(clk), .rst(rst), .regAddr(regAddr[2]), .regData(regData[2]), .imAddr(imAddr[2]));
   sr_cpu_fetch_with_latency #(.SIZE(SIZE), .PROGRAM(PROG3)) dut3 (
      .clk(clk), .rst(rst), .regAddr(regAddr[3]), .regData(regData[3]), .imAddr(imAddr[3]));
   sr_cpu_fetch_with_latency #(.SIZE(SIZE), .PROGRAM(PROG4)) dut4 (
      .clk(clk), .rst(rst), .regAddr(regAddr[4]), .regData(regData[4]), .imAddr(imAddr[4]));

   int unsigned assertCnt = 0;
   int unsigned failCnt   = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Instruction-level reference model.
   logic [31:0] mRf [NDUT][32];
   logic [31:0] mPc [NDUT];
   bit          mExec;

   function automatic logic [31:0] progWord(input int d, input logic [31:0] wa);
      logic [ROMW-1:0] img;
      case (d)
         0:       img = PROG0;
         1:       img = PROG1;
         2:       img = PROG2;
         3:       img = PROG3;
         default: img = PROG4;
      endcase
      return img[(wa % SIZE) * 32 +: 32];
   endfunction

   task automatic execModel(input int d);
      logic [31:0] ins, a, b, res, npc, immI, immB;
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          we;
      ins  = progWord(d, mPc[d] >> 2);
      rd   = ins[11:7];
      f3   = ins[14:12];
      r1   = ins[19:15];
      r2   = ins[24:20];
      f7   = ins[31:25];
      a    = mRf[d][r1];
      b    = mRf[d][r2];
      immI = {{20{ins[31]}}, ins[31:20]};
      immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      we   = 0;
      res  = 0;
      npc  = mPc[d] + 4;
      case (ins[6:0])
         7'b0110011: begin
            we = 1;
            if (f7 == 7'h00 && f3 == 3'b000)      res = a + b;
            else if (f7 == 7'h20 && f3 == 3'b000) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'b110) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'b101) res = a >> b[4:0];
            else if (f7 == 7'h00 && f3 == 3'b011) res = (a < b) ? 32'd1 : 32'd0;
            else we = 0;
         end
         7'b0010011: if (f3 == 3'b000) begin res = a + immI; we = 1; end
         7'b0110111: begin res = {ins[31:12], 12'b0}; we = 1; end
         7'b1100011: begin
            if ((f3 == 3'b000 && a == b) || (f3 == 3'b001 && a != b)) npc = mPc[d] + immB;
         end
         default: ;
      endcase
      if (we && rd != 5'd0) mRf[d][rd] = res;
      mPc[d] = npc;
   endtask

   task automatic modelEdge();
      if (rst) begin
         for (int d = 0; d < NDUT; d++) begin
            mPc[d] = 0;
            for (int r = 0; r < 32; r++) mRf[d][r] = 0;
         end
         mExec = 0;
      end else begin
         if (mExec) for (int d = 0; d < NDUT; d++) execModel(d);
         mExec = !mExec;
      end
   endtask

   // One clock: advance model, compare imAddr, then a (possibly random) register.
   task automatic tick(input bit randAddr);
      @(posedge clk);
      modelEdge();
      #1;
      for (int d = 0; d < NDUT; d++)
         checkEq($sformatf("imAddr%0d", d), imAddr[d], mPc[d] >> 2);
      for (int d = 0; d < NDUT; d++)
         regAddr[d] = randAddr ? 5'($urandom_range(0, 31)) : 5'd10;
      #1;
      for (int d = 0; d < NDUT; d++)
         checkEq($sformatf("reg%0d_x%0d", d, regAddr[d]), regData[d], mRf[d][regAddr[d]]);
   endtask

   task automatic peek(input string tag, input int d, input logic [4:0] r, input logic [31:0] exp);
      regAddr[d] = r;
      #1;
      checkEq(tag, regData[d], exp);
   endtask

   // Expected values for the first 8 edges after release (index 0 = edge 1).
   logic [31:0] exp0Addr [8] = '{0, 1, 1, 2, 2, 2, 2, 2};
   logic [31:0] exp0A0   [8] = '{0, 5, 5, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                 32'hFFFFFFFE, 32'hFFFFFFFE};
   logic [31:0] exp1Addr [8] = '{0, 1, 1, 2, 2, 1, 1, 2};
   logic [31:0] exp1A0   [8] = '{0, 0, 0, 32'h12345000, 32'h12345000, 32'h12345000,
                                 32'h12345000, 32'h12345000};

   initial begin
      logic [31:0] trace3 [60];
      int gap;
      int rlen;

      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) regAddr[d] = 5'd10;
      repeat (3) tick(1'b0);
      checkEq("rstImAddr", imAddr[0], 32'd0);
      checkEq("rstA0", regData[0], 32'd0);

      rst = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick(n >= 8);
         trace3[n] = imAddr[3];
         if (n < 8) begin
            checkEq($sformatf("p0Addr_e%0d", n + 1), imAddr[0], exp0Addr[n]);
            checkEq($sformatf("p0A0_e%0d", n + 1), regData[0], exp0A0[n]);
            checkEq($sformatf("p1Addr_e%0d", n + 1), imAddr[1], exp1Addr[n]);
            checkEq($sformatf("p1A0_e%0d", n + 1), regData[1], exp1A0[n]);
         end
      end

      // Reset in the middle of the Fibonacci run, then replay.
      gap = $urandom_range(20, 200);
      repeat (gap) tick(1'b1);
      rst  = 1'b1;
      rlen = $urandom_range(1, 3);
      repeat (rlen) tick(1'b0);
      checkEq("midRstImAddr", imAddr[3], 32'd0);
      checkEq("midRstA0", regData[3], 32'd0);
      rst = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick(1'b1);
         checkEq($sformatf("replay%0d", n), imAddr[3], trace3[n]);
      end

      repeat (1000) tick(1'b1);

      peek("p0A0",    0, 5'd10, 32'hFFFFFFFE);
      peek("p1X0",    1, 5'd0,  32'd0);
      peek("p1A0",    1, 5'd10, 32'h12345000);
      peek("subA0",   2, 5'd10, 32'hFFFFFFFE);
      peek("sltuLt",  2, 5'd11, 32'd1);
      peek("srl31",   2, 5'd12, 32'd1);
      peek("orFF",    2, 5'd13, 32'h000000FF);
      peek("add8",    2, 5'd14, 32'd8);
      peek("sltuGe",  2, 5'd15, 32'd0);
      peek("nopR",    2, 5'd16, 32'd0);
      peek("nopI",    2, 5'd17, 32'd0);
      peek("fibA0",   3, 5'd10, 32'h00213D05);
      peek("factA0",  4, 5'd10, 32'h1C8CFC00);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
